// File: rtl/sb_pkg.sv
// Shared types and helpers for the store buffer.
// Access-type encodings, the FIFO entry layout and the store legality check.
package sb_pkg;

    localparam logic [2:0] TYPE_B  = 3'b000;
    localparam logic [2:0] TYPE_H  = 3'b001;
    localparam logic [2:0] TYPE_W  = 3'b010;
    localparam logic [2:0] TYPE_BU = 3'b011;
    localparam logic [2:0] TYPE_HU = 3'b100;

    localparam int SB_ADDR_W = 32;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [31:0]          data;
        logic [2:0]           typ;
    } sb_entry_t;

    function automatic logic st_legal(input logic [2:0] t,
                                      input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        unique case (1'b1)
            (t == TYPE_B): ok = 1'b1;
            (t == TYPE_H): ok = !off[0];
            (t == TYPE_W): ok = (off == 2'b00);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/sb_byte_mask.sv
// Byte-lane mask for an access of a given type at a given byte offset.
// Lanes shifted past byte 3 are dropped, so misaligned accesses truncate.
module sb_byte_mask
    import sb_pkg::*;
(
    input  logic [2:0] typ,
    input  logic [1:0] off,
    output logic [3:0] mask
);

    logic [3:0] base;

    always_comb begin
        base = 4'b1111;
        unique case (1'b1)
            (typ == TYPE_B || typ == TYPE_BU): base = 4'b0001;
            (typ == TYPE_H || typ == TYPE_HU): base = 4'b0011;
            default:                           base = 4'b1111;
        endcase
    end

    assign mask = base << off;

endmodule

// File: rtl/store_buffer.sv
// FIFO of committed stores draining into data_memory, with load-overlap detection.
// Define STORE_BUF_FWD_EN to forward fully covered loads from the youngest match.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    input  logic [2:0]        st_type,
    output logic              st_ready,
    output logic              st_err,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [2:0]        ld_type,
    output logic              ld_hazard,
    input  logic              mem_grant,
    output logic              store,
    output logic [ADDR_W-1:0] direccion,
    output logic [31:0]       store_data,
    output logic [31:0]       offset,
    output logic [2:0]        Type,
    output logic              empty,
    output logic              fwd_valid,
    output logic [31:0]       fwd_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t        ent_q [DEPTH];
    sb_entry_t        last_q;
    sb_entry_t        head_e;
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    cnt_q;
    logic             st_err_q;
    logic             legal;
    logic             enq;
    logic             deq;
    logic [3:0]       ld_mask;
    logic [3:0]       ent_mask [DEPTH];
    logic [DEPTH-1:0] live;
    logic [DEPTH-1:0] hit;

    assign st_ready = cnt_q < CW'(DEPTH);
    assign legal    = st_legal(st_type, st_addr[1:0]);
    assign enq      = st_valid && st_ready && legal;
    assign deq      = (cnt_q != '0) && mem_grant;
    assign store    = deq;
    assign empty    = (cnt_q == '0);
    assign st_err   = st_err_q;
    assign offset   = '0;

    // While empty, the port shows the last drained entry rather than a stale slot.
    assign head_e     = empty ? last_q : ent_q[head_q];
    assign direccion  = head_e.addr[ADDR_W-1:0];
    assign store_data = head_e.data;
    assign Type       = head_e.typ;

    sb_byte_mask u_ld_mask (
        .typ  (ld_type),
        .off  (ld_addr[1:0]),
        .mask (ld_mask)
    );

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [PW-1:0] rel;
        assign rel     = PW'(i) - head_q;
        assign live[i] = CW'(rel) < cnt_q;

        sb_byte_mask u_mask (
            .typ  (ent_q[i].typ),
            .off  (ent_q[i].addr[1:0]),
            .mask (ent_mask[i])
        );

        assign hit[i] = live[i]
            && (ent_q[i].addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2])
            && ((ent_mask[i] & ld_mask) != 4'b0000);
    end

`ifdef STORE_BUF_FWD_EN
    logic          sel_hit;
    logic [PW-1:0] sel_idx;
    logic [PW-1:0] idx;
    logic          cover;
    sb_entry_t     sel_e;
    logic [31:0]   wword;
    logic [31:0]   lword;
    logic [31:0]   ext;

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        sel_hit = 1'b0;
        sel_idx = '0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (hit[idx]) begin
                sel_hit = 1'b1;
                sel_idx = idx;
            end
        end
    end

    assign sel_e = ent_q[sel_idx];
    assign cover = sel_hit
        && ((ent_mask[sel_idx] & ld_mask) == ld_mask);
    assign wword = sel_e.data << {sel_e.addr[1:0], 3'b000};
    assign lword = wword >> {ld_addr[1:0], 3'b000};

    always_comb begin
        ext = lword;
        unique case (1'b1)
            (ld_type == TYPE_B):  ext = {{24{lword[7]}}, lword[7:0]};
            (ld_type == TYPE_H):  ext = {{16{lword[15]}}, lword[15:0]};
            (ld_type == TYPE_BU): ext = {24'd0, lword[7:0]};
            (ld_type == TYPE_HU): ext = {16'd0, lword[15:0]};
            default:              ext = lword;
        endcase
    end

    assign fwd_valid = ld_valid && cover;
    assign fwd_data  = fwd_valid ? ext : 32'd0;
    assign ld_hazard = ld_valid && (|hit) && !cover;
`else
    assign fwd_valid = 1'b0;
    assign fwd_data  = 32'd0;
    assign ld_hazard = ld_valid && (|hit);
`endif

    always_ff @(posedge clk) begin
        if (enq) begin
            ent_q[tail_q] <= '{addr: SB_ADDR_W'(st_addr),
                               data: st_data,
                               typ:  st_type};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q   <= '0;
            tail_q   <= '0;
            cnt_q    <= '0;
            st_err_q <= 1'b0;
            last_q   <= '0;
        end else begin
            st_err_q <= st_valid && st_ready && !legal;
            if (enq) begin
                tail_q <= tail_q + PW'(1);
            end
            if (deq) begin
                head_q <= head_q + PW'(1);
                last_q <= ent_q[head_q];
            end
            if (enq && !deq) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (deq && !enq) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed bench for store_buffer against a queue-based model.
// Forwarding expectations follow STORE_BUF_FWD_EN when it is defined.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [2:0]  st_type = '0;
    logic        st_ready;
    logic        st_err;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [2:0]  ld_type = '0;
    logic        ld_hazard;
    logic        mem_grant = 1'b0;
    logic        store;
    logic [31:0] direccion;
    logic [31:0] store_data;
    logic [31:0] offset;
    logic [2:0]  Type;
    logic        empty;
    logic        fwd_valid;
    logic [31:0] fwd_data;

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .st_type(st_type), .st_ready(st_ready), .st_err(st_err),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_type(ld_type),
        .ld_hazard(ld_hazard), .mem_grant(mem_grant), .store(store),
        .direccion(direccion), .store_data(store_data), .offset(offset),
        .Type(Type), .empty(empty),
        .fwd_valid(fwd_valid), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  t;
    } ent_t;

    ent_t q[$];
    ent_t last;
    bit   have_last = 0;
    bit   err_exp = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] mask_of(input logic [2:0] t,
                                           input logic [1:0] off);
        logic [3:0] m;
        int sz;
        int o;
        m = 4'b0000;
        o = int'(off);
        sz = (t == 3'd0 || t == 3'd3) ? 1 : (t == 3'd1 || t == 3'd4) ? 2 : 4;
        for (int b = 0; b < sz; b++)
            if (o + b < 4) m[o + b] = 1'b1;
        return m;
    endfunction

    function automatic bit legal_st(input logic [2:0] t, input logic [31:0] a);
        if (t == 3'd0) return 1;
        if (t == 3'd1) return a[0] == 1'b0;
        if (t == 3'd2) return a[1:0] == 2'b00;
        return 0;
    endfunction

    task automatic ld_model(input logic lv, input logic [31:0] la,
                            input logic [2:0] lt, output logic hz,
                            output logic fv, output logic [31:0] fd);
        logic [3:0] ml;
        int y;
        ml = mask_of(lt, la[1:0]);
        y = -1;
        for (int i = 0; i < q.size(); i++)
            if (q[i].a[31:2] == la[31:2]
                && (mask_of(q[i].t, q[i].a[1:0]) & ml) != 4'b0)
                y = i;
        hz = lv && (y >= 0);
        fv = 1'b0;
        fd = 32'd0;
`ifdef STORE_BUF_FWD_EN
        if (lv && y >= 0
            && (mask_of(q[y].t, q[y].a[1:0]) & ml) == ml) begin
            logic [7:0] by [4];
            logic [31:0] v;
            for (int m = 0; m < 4; m++) begin
                int lane;
                lane = int'(la[1:0]) + m;
                by[m] = 8'h00;
                if (lane < 4 && ml[lane])
                    by[m] = q[y].d[8*(lane - int'(q[y].a[1:0])) +: 8];
            end
            v = {by[3], by[2], by[1], by[0]};
            case (lt)
                3'd0: fd = {{24{v[7]}}, v[7:0]};
                3'd1: fd = {{16{v[15]}}, v[15:0]};
                3'd3: fd = {24'd0, v[7:0]};
                3'd4: fd = {16'd0, v[15:0]};
                default: fd = v;
            endcase
            fv = 1'b1;
            hz = 1'b0;
        end
`endif
    endtask

    task automatic step(input logic sv, input logic [31:0] sa,
                        input logic [31:0] sd, input logic [2:0] st,
                        input logic lv, input logic [31:0] la,
                        input logic [2:0] lt, input logic g);
        logic hz, fv, rdy, stb, acc, errn;
        logic [31:0] fd;
        @(negedge clk);
        st_valid = sv; st_addr = sa; st_data = sd; st_type = st;
        ld_valid = lv; ld_addr = la; ld_type = lt; mem_grant = g;
        #1;
        rdy = q.size() < DEPTH;
        stb = (q.size() != 0) && g;
        chk("st_ready", st_ready, rdy);
        chk("empty", empty, q.size() == 0);
        chk("store", store, stb);
        chk("st_err", st_err, err_exp);
        chk("offset", offset, 32'd0);
        if (q.size() != 0) begin
            chk("direccion", direccion, q[0].a);
            chk("store_data", store_data, q[0].d);
            chk("Type", Type, q[0].t);
        end else if (have_last) begin
            chk("hold_dir", direccion, last.a);
            chk("hold_data", store_data, last.d);
        end
        ld_model(lv, la, lt, hz, fv, fd);
        chk("ld_hazard", ld_hazard, hz);
        chk("fwd_valid", fwd_valid, fv);
        chk("fwd_data", fwd_data, fd);
        acc  = sv && rdy && legal_st(st, sa);
        errn = sv && rdy && !legal_st(st, sa);
        @(posedge clk);
        if (stb) begin
            last = q.pop_front();
            have_last = 1;
        end
        if (acc) q.push_back('{a: sa, d: sd, t: st});
        err_exp = errn;
    endtask

    task automatic idle(input logic g);
        step(0, 0, 0, 0, 0, 0, 0, g);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        st_valid = 0; ld_valid = 1; ld_addr = q[0].a; ld_type = 3'd2;
        mem_grant = 1;
        #2 rst_n = 0;
        #1;
        chk("rst_empty", empty, 1'b1);
        chk("rst_store", store, 1'b0);
        chk("rst_ready", st_ready, 1'b1);
        chk("rst_hazard", ld_hazard, 1'b0);
        chk("rst_fwd", fwd_valid, 1'b0);
        q.delete();
        err_exp = 0;
        have_last = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        mem_grant = 1; ld_valid = 1; ld_addr = 32'h0; ld_type = 3'd2;
        #12;
        chk("reset_empty", empty, 1'b1);
        chk("reset_store", store, 1'b0);
        chk("reset_ready", st_ready, 1'b1);
        chk("reset_hazard", ld_hazard, 1'b0);
        chk("reset_err", st_err, 1'b0);
        chk("reset_fwd", fwd_valid, 1'b0);
        @(negedge clk);
        rst_n = 1;

        step(1, 32'h0, 32'h4000E081, 3'd2, 0, 0, 0, 0);
        idle(0);
        idle(1);
        idle(0);
        chk("drained_empty", empty, 1'b1);

        for (int i = 0; i < 4; i++)
            step(1, 32'h10 + 4*i, 32'hA000 + i, 3'd2, 0, 0, 0, 0);
        step(1, 32'h20, 32'hBEEF, 3'd2, 0, 0, 0, 0);
        step(1, 32'h20, 32'hBEEF, 3'd2, 0, 0, 0, 1);
        step(1, 32'h20, 32'hBEEF, 3'd2, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) idle(1);

        step(1, 32'hC, 32'h55, 3'd0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'hC, 3'd2, 0);
        step(0, 0, 0, 0, 1, 32'h10, 3'd2, 0);
        step(0, 0, 0, 0, 1, 32'hD, 3'd0, 0);
        idle(1);
        step(1, 32'hC, 32'h0400E0FF, 3'd2, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'hC, 3'd3, 0);
        step(0, 0, 0, 0, 1, 32'hE, 3'd1, 0);
        idle(1);

        step(1, 32'h3, 32'h1234, 3'd1, 0, 0, 0, 0);
        step(1, 32'h8, 32'h1234, 3'd3, 0, 0, 0, 0);
        idle(0);
        chk("err_empty", empty, 1'b1);

        for (int i = 0; i < 3; i++)
            step(1, 32'h40 + 4*i, 32'hC0 + i, 3'd2, 0, 0, 0, 0);
        mid_reset();

        for (int c = 0; c < 1500; c++) begin
            logic sv, lv, g;
            logic [31:0] sa, la;
            logic [2:0] st, lt;
            sv = ($urandom_range(0, 9) < 6);
            sa = 32'($urandom_range(0, 31));
            st = 3'($urandom_range(0, 9) < 8 ? $urandom_range(0, 2)
                                             : $urandom_range(3, 7));
            if (q.size() == DEPTH || $urandom_range(0, 3) != 0) begin
                if (st > 3'd2) st = 3'd0;
                if (st == 3'd1) sa[0] = 1'b0;
                if (st == 3'd2) sa[1:0] = 2'b00;
            end
            lv = ($urandom_range(0, 1) == 1);
            la = 32'($urandom_range(0, 31));
            lt = 3'($urandom_range(0, 4));
            g  = ($urandom_range(0, 9) < 4);
            step(sv, sa, $urandom, st, lv, la, lt, g);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
